// File: rtl/id_ex_pipeline_reg_if.sv
// ============================================================================
// Module      : id_ex_pipeline_reg_if
// Description : ID->EX pipeline register bundle (ID-side inputs, EX-side
//               outputs, hold/flush/stall control).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_pipeline_reg_if;
  logic        HOLD;
  logic        FLUSH;

  logic        OP1SEL_IN;
  logic        OP2SEL_IN;
  logic        REG_WRITE_EN_IN;
  logic [1:0]  WB_SEL_IN;
  logic [4:0]  ALUOP_IN;
  logic [2:0]  BRANCH_JUMP_IN;
  logic [3:0]  READ_WRITE_IN;
  logic [31:0] PC_IN;
  logic [31:0] DATA1_IN;
  logic [31:0] DATA2_IN;
  logic [31:0] IMM_IN;
  logic [4:0]  RD_IN;
  logic [4:0]  RS1_IN;
  logic [4:0]  RS2_IN;

  logic        OP1SEL_OUT;
  logic        OP2SEL_OUT;
  logic        REG_WRITE_EN_OUT;
  logic [1:0]  WB_SEL_OUT;
  logic [4:0]  ALUOP_OUT;
  logic [2:0]  BRANCH_JUMP_OUT;
  logic [3:0]  READ_WRITE_OUT;
  logic [31:0] PC_OUT;
  logic [31:0] DATA1_OUT;
  logic [31:0] DATA2_OUT;
  logic [31:0] IMM_OUT;
  logic [4:0]  RD_OUT;
  logic [4:0]  RS1_OUT;
  logic [4:0]  RS2_OUT;
  logic        VALID_OUT;
  logic        STALL_OUT;

  modport master (
    output HOLD, FLUSH,
    output OP1SEL_IN, OP2SEL_IN, REG_WRITE_EN_IN, WB_SEL_IN, ALUOP_IN,
    output BRANCH_JUMP_IN, READ_WRITE_IN, PC_IN, DATA1_IN, DATA2_IN, IMM_IN,
    output RD_IN, RS1_IN, RS2_IN,
    input  OP1SEL_OUT, OP2SEL_OUT, REG_WRITE_EN_OUT, WB_SEL_OUT, ALUOP_OUT,
    input  BRANCH_JUMP_OUT, READ_WRITE_OUT, PC_OUT, DATA1_OUT, DATA2_OUT,
    input  IMM_OUT, RD_OUT, RS1_OUT, RS2_OUT, VALID_OUT, STALL_OUT
  );

  modport slave (
    input  HOLD, FLUSH,
    input  OP1SEL_IN, OP2SEL_IN, REG_WRITE_EN_IN, WB_SEL_IN, ALUOP_IN,
    input  BRANCH_JUMP_IN, READ_WRITE_IN, PC_IN, DATA1_IN, DATA2_IN, IMM_IN,
    input  RD_IN, RS1_IN, RS2_IN,
    output OP1SEL_OUT, OP2SEL_OUT, REG_WRITE_EN_OUT, WB_SEL_OUT, ALUOP_OUT,
    output BRANCH_JUMP_OUT, READ_WRITE_OUT, PC_OUT, DATA1_OUT, DATA2_OUT,
    output IMM_OUT, RD_OUT, RS1_OUT, RS2_OUT, VALID_OUT, STALL_OUT
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_pipeline_reg.sv
// ============================================================================
// Module      : id_ex_pipeline_reg
// Description : RV32IM ID->EX pipeline register with load-use bubble
//               insertion, branch flush and global hold.
//               Optional macro LOAD_USE_DETECT_EN enables hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipeline_reg (
  input  logic                 CLK,
  input  logic                 RESET,
  id_ex_pipeline_reg_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic        op1sel;
    logic        op2sel;
    logic        reg_write_en;
    logic [1:0]  wb_sel;
    logic [4:0]  aluop;
    logic [2:0]  branch_jump;
    logic [3:0]  read_write;
    logic [31:0] pc;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ex_entry_t;

  // Bubble is a NOP: no writeback, no memory access, no-branch code 3'b010.
  localparam ex_entry_t c_BUBBLE = '{
    valid: 1'b0, op1sel: 1'b0, op2sel: 1'b0, reg_write_en: 1'b0,
    wb_sel: 2'b00, aluop: 5'd0, branch_jump: 3'b010, read_write: 4'b0000,
    pc: 32'd0, data1: 32'd0, data2: 32'd0, imm: 32'd0,
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0
  };

  ex_entry_t entry_q;
  ex_entry_t entry_d;
  ex_entry_t w_id_entry;
  logic      w_load_use;

  assign w_id_entry = '{
    valid: 1'b1, op1sel: bus.OP1SEL_IN, op2sel: bus.OP2SEL_IN,
    reg_write_en: bus.REG_WRITE_EN_IN, wb_sel: bus.WB_SEL_IN,
    aluop: bus.ALUOP_IN, branch_jump: bus.BRANCH_JUMP_IN,
    read_write: bus.READ_WRITE_IN, pc: bus.PC_IN, data1: bus.DATA1_IN,
    data2: bus.DATA2_IN, imm: bus.IMM_IN, rd: bus.RD_IN,
    rs1: bus.RS1_IN, rs2: bus.RS2_IN
  };

`ifdef LOAD_USE_DETECT_EN
  // Source match is format-agnostic; a false hit only costs one bubble.
  assign w_load_use = entry_q.valid
                   && (entry_q.wb_sel == 2'b01)
                   && entry_q.reg_write_en
                   && (entry_q.rd != 5'd0)
                   && ((entry_q.rd == bus.RS1_IN) || (entry_q.rd == bus.RS2_IN));
`else
  assign w_load_use = 1'b0;
`endif

  assign bus.STALL_OUT = w_load_use & ~bus.FLUSH & ~bus.HOLD;

  always_comb begin
    entry_d = entry_q;
    if (bus.HOLD) begin
      entry_d = entry_q;
    end else if (bus.FLUSH) begin
      entry_d = c_BUBBLE;
    end else if (w_load_use) begin
      entry_d = c_BUBBLE;
    end else begin
      entry_d = w_id_entry;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      entry_q <= c_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign bus.VALID_OUT        = entry_q.valid;
  assign bus.OP1SEL_OUT       = entry_q.op1sel;
  assign bus.OP2SEL_OUT       = entry_q.op2sel;
  assign bus.REG_WRITE_EN_OUT = entry_q.reg_write_en;
  assign bus.WB_SEL_OUT       = entry_q.wb_sel;
  assign bus.ALUOP_OUT        = entry_q.aluop;
  assign bus.BRANCH_JUMP_OUT  = entry_q.branch_jump;
  assign bus.READ_WRITE_OUT   = entry_q.read_write;
  assign bus.PC_OUT           = entry_q.pc;
  assign bus.DATA1_OUT        = entry_q.data1;
  assign bus.DATA2_OUT        = entry_q.data2;
  assign bus.IMM_OUT          = entry_q.imm;
  assign bus.RD_OUT           = entry_q.rd;
  assign bus.RS1_OUT          = entry_q.rs1;
  assign bus.RS2_OUT          = entry_q.rs2;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
// ============================================================================
// Module      : tb_id_ex_pipeline_reg
// Description : Directed self-checking bench for id_ex_pipeline_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic        valid;
    logic        op1sel;
    logic        op2sel;
    logic        rwe;
    logic [1:0]  wb;
    logic [4:0]  alu;
    logic [2:0]  bj;
    logic [3:0]  rw;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ent_t;

`ifdef LOAD_USE_DETECT_EN
  localparam logic c_LU_EN = 1'b1;
`else
  localparam logic c_LU_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg_if bus ();

  id_ex_pipeline_reg dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  function automatic ent_t mk(input logic o1, input logic o2, input logic we,
                              input logic [1:0] wb, input logic [4:0] alu,
                              input logic [3:0] rw, input logic [31:0] pc,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2);
    ent_t e;
    e = '{valid: 1'b1, op1sel: o1, op2sel: o2, rwe: we, wb: wb, alu: alu,
          bj: 3'b010, rw: rw, pc: pc, d1: d1, d2: d2, imm: imm,
          rd: rd, rs1: rs1, rs2: rs2};
    return e;
  endfunction

  task automatic drive(input ent_t e);
    bus.OP1SEL_IN       = e.op1sel;
    bus.OP2SEL_IN       = e.op2sel;
    bus.REG_WRITE_EN_IN = e.rwe;
    bus.WB_SEL_IN       = e.wb;
    bus.ALUOP_IN        = e.alu;
    bus.BRANCH_JUMP_IN  = e.bj;
    bus.READ_WRITE_IN   = e.rw;
    bus.PC_IN           = e.pc;
    bus.DATA1_IN        = e.d1;
    bus.DATA2_IN        = e.d2;
    bus.IMM_IN          = e.imm;
    bus.RD_IN           = e.rd;
    bus.RS1_IN          = e.rs1;
    bus.RS2_IN          = e.rs2;
  endtask

  function automatic ent_t observe();
    ent_t e;
    e = '{valid: bus.VALID_OUT, op1sel: bus.OP1SEL_OUT, op2sel: bus.OP2SEL_OUT,
          rwe: bus.REG_WRITE_EN_OUT, wb: bus.WB_SEL_OUT, alu: bus.ALUOP_OUT,
          bj: bus.BRANCH_JUMP_OUT, rw: bus.READ_WRITE_OUT, pc: bus.PC_OUT,
          d1: bus.DATA1_OUT, d2: bus.DATA2_OUT, imm: bus.IMM_OUT,
          rd: bus.RD_OUT, rs1: bus.RS1_OUT, rs2: bus.RS2_OUT};
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [191:0] got,
                          input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  ent_t bubble, e_rand, add3, xori4, lw5, add6, lw0, add8, lw5b, ex_exp;

  // Dependent consumer behind a load in EX: one stall cycle and one bubble
  // when detection is built in, otherwise captured on the first edge.
  task automatic dep_pair(input string tag, input ent_t e);
    drive(e);
    #1;
    check_eq({tag, "_stall"}, 192'(bus.STALL_OUT), 192'(c_LU_EN));
    tick();
    ex_exp = c_LU_EN ? bubble : e;
    check_eq({tag, "_ex1"}, 192'(observe()), 192'(ex_exp));
    check_eq({tag, "_stall2"}, 192'(bus.STALL_OUT), 192'(1'b0));
    tick();
    check_eq({tag, "_ex2"}, 192'(observe()), 192'(e));
  endtask

  initial begin
    bubble = '{valid: 1'b0, op1sel: 1'b0, op2sel: 1'b0, rwe: 1'b0, wb: 2'b00,
               alu: 5'd0, bj: 3'b010, rw: 4'b0000, pc: 32'd0, d1: 32'd0,
               d2: 32'd0, imm: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};
    add3  = mk(1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 4'b0000, 32'h100, 32'd11, 32'd22, 32'd0, 5'd3, 5'd1, 5'd2);
    xori4 = mk(1'b0, 1'b1, 1'b1, 2'b10, 5'd4, 4'b0000, 32'h104, 32'd33, 32'hDEAD, 32'd5, 5'd4, 5'd3, 5'd5);
    lw5   = mk(1'b0, 1'b1, 1'b1, 2'b01, 5'd0, 4'b1010, 32'h108, 32'h1000, 32'd0, 32'd0, 5'd5, 5'd1, 5'd0);
    add6  = mk(1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 4'b0000, 32'h10C, 32'h77, 32'h88, 32'd0, 5'd6, 5'd5, 5'd7);
    lw0   = mk(1'b0, 1'b1, 1'b1, 2'b01, 5'd0, 4'b1010, 32'h110, 32'h1000, 32'd0, 32'd0, 5'd0, 5'd1, 5'd0);
    add8  = mk(1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 4'b0000, 32'h114, 32'd0, 32'd0, 32'd0, 5'd8, 5'd0, 5'd0);
    lw5b  = mk(1'b0, 1'b1, 1'b1, 2'b01, 5'd0, 4'b1010, 32'h118, 32'h2000, 32'd0, 32'd4, 5'd5, 5'd5, 5'd4);

    bus.HOLD  = 1'b0;
    bus.FLUSH = 1'b0;
    rst_n     = 1'b0;

    // Reset with arbitrary ID inputs
    for (int i = 0; i < 2; i++) begin
      e_rand = ent_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      drive(e_rand);
      tick();
      check_eq("reset_ex", 192'(observe()), 192'(bubble));
      check_eq("reset_stall", 192'(bus.STALL_OUT), 192'(1'b0));
    end

    // Streaming
    rst_n = 1'b1;
    drive(add3);
    #1;
    check_eq("add_stall", 192'(bus.STALL_OUT), 192'(1'b0));
    tick();
    check_eq("add_ex", 192'(observe()), 192'(add3));
    drive(xori4);
    #1;
    check_eq("xori_stall", 192'(bus.STALL_OUT), 192'(1'b0));
    tick();
    check_eq("xori_ex", 192'(observe()), 192'(xori4));

    // Load-use
    drive(lw5);
    tick();
    check_eq("lw_ex", 192'(observe()), 192'(lw5));
    dep_pair("lu", add6);

    // Load into x0 never stalls
    drive(lw0);
    tick();
    check_eq("lw0_ex", 192'(observe()), 192'(lw0));
    drive(add8);
    #1;
    check_eq("x0_stall", 192'(bus.STALL_OUT), 192'(1'b0));
    tick();
    check_eq("x0_ex", 192'(observe()), 192'(add8));

    // Load-use together with flush
    drive(lw5);
    tick();
    bus.FLUSH = 1'b1;
    drive(add6);
    #1;
    check_eq("flush_stall", 192'(bus.STALL_OUT), 192'(1'b0));
    tick();
    check_eq("flush_ex", 192'(observe()), 192'(bubble));
    bus.FLUSH = 1'b0;

    // Load-use together with hold
    drive(lw5);
    tick();
    bus.HOLD = 1'b1;
    drive(add6);
    #1;
    check_eq("hold_stall", 192'(bus.STALL_OUT), 192'(1'b0));
    tick();
    check_eq("hold_ex", 192'(observe()), 192'(lw5));
    bus.HOLD = 1'b0;
    dep_pair("lu_after_hold", add6);

    // Back-to-back loads into the same rd
    drive(lw5);
    tick();
    dep_pair("b2b_load", lw5b);
    dep_pair("b2b_use", add6);

    // Hold for three cycles, then reset while still held
    drive(add3);
    tick();
    check_eq("pre_hold_ex", 192'(observe()), 192'(add3));
    bus.HOLD = 1'b1;
    drive(xori4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_freeze", 192'(observe()), 192'(add3));
    end
    rst_n = 1'b0;
    tick();
    check_eq("hold_reset_ex", 192'(observe()), 192'(bubble));
    check_eq("hold_reset_stall", 192'(bus.STALL_OUT), 192'(1'b0));
    rst_n    = 1'b1;
    bus.HOLD = 1'b0;
    tick();
    check_eq("post_reset_ex", 192'(observe()), 192'(xori4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
